outport_credit: RTL

OUTPORT_CREDIT -- requirements
Module: outport_credit

---
 rtl/outport_credit_pkg.sv | 26 ++
 rtl/outport_vc_state.sv | 81 ++++++++
 rtl/outport_credit.sv | 99 +++++++++
 3 files changed

// File: rtl/outport_credit_pkg.sv
// Shared NoC definitions for the output-port credit block: flit layout,
// flit-type encodings and the per-VC lock FSM state encoding.
package outport_credit_pkg;

  localparam int DATAW    = 32;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    LCK_IDLE  = 2'b00,
    LCK_BUSY  = 2'b01,
    LCK_DRAIN = 2'b10
  } lck_state_e;

  function automatic flit_type_e flit_type(input logic [DATAW-1:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/outport_vc_state.sv
// One virtual channel: downstream credit counter plus packet lock FSM.
// Error outputs are single-cycle pulses; the top makes them sticky.
module outport_vc_state
  import outport_credit_pkg::*;
#(
  parameter int FIFOD  = 8,
  parameter int PKTLEN = 4,
  parameter int CW     = $clog2(FIFOD + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          send,
  input  flit_type_e    ftype,
  input  logic          ack,
  input  logic          ilck,
  output logic [CW-1:0] cnt,
  output logic          rdy,
  output logic          lck,
  output logic          err_proto,
  output logic          err_udf,
  output logic          err_ovf
);

  lck_state_e state, state_nxt;

  logic cnt_full, cnt_empty;
  assign cnt_full  = (cnt == CW'(FIFOD));
  assign cnt_empty = (cnt == '0);

  // A simultaneous send and credit return cancel out.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (send && !ack) begin
      if (!cnt_full) cnt <= cnt + 1'b1;
    end else if (ack && !send) begin
      if (!cnt_empty) cnt <= cnt - 1'b1;
    end
  end

  assign err_ovf = send && !ack && cnt_full;
  assign err_udf = ack && !send && cnt_empty;
  assign rdy     = (cnt <= CW'(FIFOD - PKTLEN));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= LCK_IDLE;
    else       state <= state_nxt;
  end

  // Illegal flit types leave the state untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      LCK_IDLE: begin
        if (send && ftype == FT_HEAD)          state_nxt = LCK_BUSY;
        else if (send && ftype == FT_HEADTAIL) state_nxt = LCK_DRAIN;
      end
      LCK_BUSY: begin
        if (send && ftype == FT_TAIL) state_nxt = LCK_DRAIN;
      end
      LCK_DRAIN: begin
        if (send && ftype == FT_HEAD)          state_nxt = LCK_BUSY;
        else if (send && ftype == FT_HEADTAIL) state_nxt = LCK_DRAIN;
        else if (!send && !ilck)               state_nxt = LCK_IDLE;
      end
      default: state_nxt = LCK_IDLE;
    endcase
  end

  always_comb begin
    lck       = (state != LCK_IDLE);
    err_proto = 1'b0;
    if (send) begin
      case (state)
        LCK_BUSY: err_proto = (ftype == FT_HEAD) || (ftype == FT_HEADTAIL);
        default:  err_proto = (ftype == FT_BODY) || (ftype == FT_TAIL);
      endcase
    end
  end

endmodule

// File: rtl/outport_credit.sv
// Output port of a NoC router: forwards flits to the link, tracks
// downstream credits and packet locks per VC, and latches sticky errors.
module outport_credit
  import outport_credit_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int NVCH     = 2,
  parameter int FIFOD    = 8,
  parameter int PKTLEN   = 4,
  parameter int REGOUT   = 1,
  localparam int VCHW    = $clog2(NVCH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch,
  input  logic [NVCH-1:0]  iack,
  output logic [NVCH-1:0]  ordy,
  input  logic [NVCH-1:0]  ilck,
  output logic [NVCH-1:0]  olck,
  output logic [2:0]       oerr
);

  localparam int CW = $clog2(FIFOD + 1);

  if (NVCH < 2 || NVCH > 8 || PKTLEN > FIFOD || PKTLEN < 1 || ROUTERID < 0 || PCHID < 0)
  begin : g_bad_cfg
    $error("outport_credit: illegal parameter set");
  end

  flit_type_e      ftype;
  logic            vch_ok;
  logic [NVCH-1:0] send, err_proto, err_udf, err_ovf;

  assign ftype  = flit_type(idata);
  assign vch_ok = (int'(ivch) < NVCH);

  for (genvar v = 0; v < NVCH; v++) begin : g_vc
    logic [CW-1:0] cnt;
    assign send[v] = ivalid && vch_ok && (ivch == VCHW'(v));
    outport_vc_state #(
      .FIFOD  (FIFOD),
      .PKTLEN (PKTLEN),
      .CW     (CW)
    ) u_vc (
      .clk       (clk),
      .rst_      (rst_),
      .send      (send[v]),
      .ftype     (ftype),
      .ack       (iack[v]),
      .ilck      (ilck[v]),
      .cnt       (cnt),
      .rdy       (ordy[v]),
      .lck       (olck[v]),
      .err_proto (err_proto[v]),
      .err_udf   (err_udf[v]),
      .err_ovf   (err_ovf[v])
    );
  end

  // Out-of-range VC ids count as protocol errors but touch no VC state.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) oerr <= '0;
    else       oerr <= oerr | {(|err_proto) || (ivalid && !vch_ok), |err_udf, |err_ovf};
  end

  if (REGOUT != 0) begin : g_regout
    logic [DATAW-1:0] data_p1;
    logic             vld_p1;
    logic [VCHW-1:0]  vch_p1;

    // Link stage: idle cycles drive zeros rather than stale data.
    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
        vch_p1  <= '0;
      end else begin
        data_p1 <= ivalid ? idata : '0;
        vld_p1  <= ivalid;
        vch_p1  <= ivalid ? ivch : '0;
      end
    end

    assign odata  = data_p1;
    assign ovalid = vld_p1;
    assign ovch   = vch_p1;
  end else begin : g_passout
    assign odata  = idata;
    assign ovalid = ivalid;
    assign ovch   = ivch;
  end

endmodule
